// File: rtl/uart_disp_pkg.sv
// Shared definitions for the UART-to-display path: ASCII codes, parser
// state encoding and the byte classification used by the hex parser.
package uart_disp_pkg;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_0  = 8'h30;
    localparam logic [7:0] CHAR_9  = 8'h39;
    localparam logic [7:0] CHAR_A  = 8'h41;
    localparam logic [7:0] CHAR_F  = 8'h46;
    localparam logic [7:0] CHAR_a  = 8'h61;
    localparam logic [7:0] CHAR_f  = 8'h66;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        OVF   = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        HEX   = 2'd0,
        TERM  = 2'd1,
        OTHER = 2'd2
    } byte_class_t;

    // Collapse the decoder flags into a single class; hex takes priority,
    // although the decoder never raises both flags together.
    function automatic byte_class_t classify(input logic is_hex, input logic is_term);
        byte_class_t cls;
        if (is_hex) begin
            cls = HEX;
        end else if (is_term) begin
            cls = TERM;
        end else begin
            cls = OTHER;
        end
        return cls;
    endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Purely combinational ASCII decoder: recognises hex digits (either case)
// and line terminators, and yields the nibble value of a hex digit.
module ascii_hex_decode
    import uart_disp_pkg::*;
(
    input  logic [7:0] rx_byte,
    output logic       is_hex,
    output logic       is_term,
    output logic [3:0] nib
);

    logic [7:0] off_digit_s;
    logic [7:0] off_upper_s;
    logic [7:0] off_lower_s;

    assign off_digit_s = rx_byte - CHAR_0;
    assign off_upper_s = rx_byte - CHAR_A + 8'd10;
    assign off_lower_s = rx_byte - CHAR_a + 8'd10;

    // Classify the byte and pick the matching nibble offset.
    always_comb begin
        is_hex  = 1'b0;
        is_term = 1'b0;
        nib     = 4'd0;
        if ((rx_byte >= CHAR_0) && (rx_byte <= CHAR_9)) begin
            is_hex = 1'b1;
            nib    = off_digit_s[3:0];
        end else if ((rx_byte >= CHAR_A) && (rx_byte <= CHAR_F)) begin
            is_hex = 1'b1;
            nib    = off_upper_s[3:0];
        end else if ((rx_byte >= CHAR_a) && (rx_byte <= CHAR_f)) begin
            is_hex = 1'b1;
            nib    = off_lower_s[3:0];
        end else if ((rx_byte == CHAR_CR) || (rx_byte == CHAR_LF)) begin
            is_term = 1'b1;
        end else begin
            is_hex  = 1'b0;
            is_term = 1'b0;
        end
    end

endmodule

// File: rtl/uart_hex_parser.sv
// Assembles up to NDIGITS ASCII hex digits into a word and publishes it on
// Data when a line terminator arrives. Malformed, overlong and stalled lines
// raise a sticky err that only reset or the next good commit clears.
module uart_hex_parser
    import uart_disp_pkg::*;
#(
    parameter int NDIGITS        = 4,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rtsn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [4*NDIGITS-1:0]   Data,
    output logic                   data_update,
    output logic [2:0]             digit_cnt,
    output logic                   err
);

    localparam int DW = 4 * NDIGITS;
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_SAT  = {TW{1'b1}};
    localparam logic [2:0] CNT_MAX   = 3'(NDIGITS);

    parse_state_t   state_r, state_n;
    logic [DW-1:0]  shadow_r, shadow_n;
    logic [DW-1:0]  data_r, data_n;
    logic [2:0]     cnt_r, cnt_n;
    logic [TW-1:0]  timer_r, timer_n;
    logic           upd_r, upd_n;
    logic           err_r, err_n;

    logic           dec_hex_s;
    logic           dec_term_s;
    logic [3:0]     dec_nib_s;
    byte_class_t    cls_s;
    logic           timeout_s;

    ascii_hex_decode u_dec (
        .rx_byte (rx_data),
        .is_hex  (dec_hex_s),
        .is_term (dec_term_s),
        .nib     (dec_nib_s)
    );

    assign cls_s     = classify(dec_hex_s, dec_term_s);
    assign timeout_s = TO_EN && (timer_r == T_LAST);

    // Next-state logic: line assembly, commit, error and stall handling.
    always_comb begin
        state_n  = state_r;
        shadow_n = shadow_r;
        data_n   = data_r;
        cnt_n    = cnt_r;
        timer_n  = timer_r;
        upd_n    = 1'b0;
        err_n    = err_r;
        case (state_r)
            IDLE: begin
                timer_n  = '0;
                shadow_n = '0;
                cnt_n    = 3'd0;
                if (rx_valid && (cls_s == HEX)) begin
                    shadow_n = {{(DW-4){1'b0}}, dec_nib_s};
                    cnt_n    = 3'd1;
                    state_n  = ACCUM;
                end else begin
                    state_n = IDLE;
                end
            end
            ACCUM, OVF: begin
                if (rx_valid) begin
                    timer_n = '0;
                    case (cls_s)
                        HEX: begin
                            if (state_r == OVF) begin
                                state_n = OVF;
                            end else if (cnt_r < CNT_MAX) begin
                                shadow_n = {shadow_r[DW-5:0], dec_nib_s};
                                cnt_n    = cnt_r + 3'd1;
                            end else begin
                                state_n = OVF;
                                err_n   = 1'b1;
                            end
                        end
                        TERM: begin
                            if (state_r == ACCUM) begin
                                data_n = shadow_r;
                                upd_n  = 1'b1;
                                err_n  = 1'b0;
                            end else begin
                                data_n = data_r;
                            end
                            shadow_n = '0;
                            cnt_n    = 3'd0;
                            state_n  = IDLE;
                        end
                        OTHER: begin
                            if (state_r == ACCUM) begin
                                err_n    = 1'b1;
                                shadow_n = '0;
                                cnt_n    = 3'd0;
                                state_n  = IDLE;
                            end else begin
                                state_n = OVF;
                            end
                        end
                        default: begin
                            state_n = IDLE;
                        end
                    endcase
                end else if (timeout_s) begin
                    err_n    = 1'b1;
                    shadow_n = '0;
                    cnt_n    = 3'd0;
                    timer_n  = '0;
                    state_n  = IDLE;
                end else if (timer_r != T_SAT) begin
                    timer_n = timer_r + TW'(1);
                end else begin
                    timer_n = timer_r;
                end
            end
            default: begin
                state_n  = IDLE;
                shadow_n = '0;
                cnt_n    = 3'd0;
                timer_n  = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rtsn) begin
            state_r  <= IDLE;
            shadow_r <= '0;
            data_r   <= '0;
            cnt_r    <= 3'd0;
            timer_r  <= '0;
            upd_r    <= 1'b0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_n;
            shadow_r <= shadow_n;
            data_r   <= data_n;
            cnt_r    <= cnt_n;
            timer_r  <= timer_n;
            upd_r    <= upd_n;
            err_r    <= err_n;
        end
    end

    assign Data        = data_r;
    assign data_update = upd_r;
    assign digit_cnt   = cnt_r;
    assign err         = err_r;

endmodule

// File: tb/tb_uart_hex_parser.sv
// Randomised and directed bench for uart_hex_parser, checked every cycle
// against a line-level model of the parser's behaviour.
module tb_uart_hex_parser;

    localparam int TMO = 100;

    logic        clk = 1'b0;
    logic        rtsn = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [15:0] Data;
    logic        data_update;
    logic [2:0]  digit_cnt;
    logic        err;

    always #5 clk = ~clk;

    uart_hex_parser #(.NDIGITS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rtsn        (rtsn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .Data        (Data),
        .data_update (data_update),
        .digit_cnt   (digit_cnt),
        .err         (err)
    );

    int n_total = 0;
    int n_pass  = 0;
    int pulses  = 0;
    bit check_en = 1'b0;

    typedef struct {
        int data;
        bit upd;
        bit err;
        bit in_line;
        bit ovf;
        int ndig;
        int val;
        int idle;
    } model_t;

    model_t m = '{default: 0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Nibble value of an ASCII hex digit, -1 for anything else.
    function automatic int nib_of(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
        return -1;
    endfunction

    // One clock of the line-level behaviour.
    function automatic model_t step(input model_t cur, input logic rst_ok, input logic v, input logic [7:0] b);
        model_t n;
        int nib;
        n = cur;
        if (!rst_ok) begin
            n = '{default: 0};
            return n;
        end
        n.upd = 1'b0;
        if (v) begin
            n.idle = 0;
            nib = nib_of(b);
            if (nib >= 0) begin
                if (!cur.in_line) begin
                    n.in_line = 1'b1;
                    n.ndig = 1;
                    n.val = nib;
                end else if (!cur.ovf) begin
                    if (cur.ndig < 4) begin
                        n.val = cur.val * 16 + nib;
                        n.ndig = cur.ndig + 1;
                    end else begin
                        n.ovf = 1'b1;
                        n.err = 1'b1;
                    end
                end
            end else if (b == 8'h0D || b == 8'h0A) begin
                if (cur.in_line && !cur.ovf) begin
                    n.data = cur.val;
                    n.upd = 1'b1;
                    n.err = 1'b0;
                end
                n.in_line = 1'b0; n.ovf = 1'b0; n.ndig = 0; n.val = 0;
            end else if (cur.in_line && !cur.ovf) begin
                n.err = 1'b1;
                n.in_line = 1'b0; n.ndig = 0; n.val = 0;
            end
        end else if (cur.in_line) begin
            n.idle = cur.idle + 1;
            if (n.idle >= TMO) begin
                n.err = 1'b1;
                n.in_line = 1'b0; n.ovf = 1'b0; n.ndig = 0; n.val = 0; n.idle = 0;
            end
        end else begin
            n.idle = 0;
        end
        return n;
    endfunction

    // Advance the model on every rising edge with the inputs the DUT sees.
    always @(posedge clk) m <= step(m, rtsn, rx_valid, rx_data);

    // Compare all outputs against the model once per cycle on the falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("Data", 32'(Data), 32'(m.data & 16'hFFFF));
            check("data_update", 32'(data_update), 32'(m.upd));
            check("digit_cnt", 32'(digit_cnt), 32'(m.ndig));
            check("err", 32'(err), 32'(m.err));
            if (data_update === 1'b1) pulses++;
        end
    end

    task automatic cyc(input logic v, input logic [7:0] d);
        @(negedge clk);
        rx_valid = v;
        rx_data  = d;
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) cyc(1'b1, s[i]);
    endtask

    task automatic idle1();
        cyc(1'b0, 8'h00);
        #1;
    endtask

    string hexchars = "0123456789ABCDEFabcdef";
    int p0;
    int r;

    initial begin
        rtsn = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        #1;
        check("reset Data", 32'(Data), 32'h0);
        check("reset err", 32'(err), 32'h0);
        check("reset digit_cnt", 32'(digit_cnt), 32'h0);
        rtsn = 1'b1;

        // basic 4-digit line
        send("1A2F\r"); p0 = pulses;
        idle1();
        check("1A2F Data", 32'(Data), 32'h1A2F);
        check("1A2F pulse", 32'(data_update), 32'h1);
        check("1A2F cnt", 32'(digit_cnt), 32'h0);
        idle1();
        check("1A2F pulse count", 32'(pulses - p0), 32'd1);

        // partial line, then an empty line
        send("7\n"); p0 = pulses;
        idle1();
        check("7 Data", 32'(Data), 32'h0007);
        send("\r"); idle1(); idle1();
        check("7 pulse count", 32'(pulses - p0), 32'd1);

        // overflow then recovery
        p0 = pulses;
        send("12345"); idle1();
        check("ovf cnt", 32'(digit_cnt), 32'd4);
        check("ovf err", 32'(err), 32'h1);
        send("\r"); idle1(); idle1();
        check("ovf Data frozen", 32'(Data), 32'h0007);
        check("ovf no pulse", 32'(pulses - p0), 32'd0);
        send("00ab\r"); idle1();
        check("00ab Data", 32'(Data), 32'h00AB);
        check("00ab err", 32'(err), 32'h0);

        // timeout after exactly TMO idle cycles
        send("12");
        repeat (TMO) cyc(1'b0, 8'h00);
        #1;
        check("pre-timeout err", 32'(err), 32'h0);
        check("pre-timeout cnt", 32'(digit_cnt), 32'd2);
        idle1();
        check("timeout err", 32'(err), 32'h1);
        check("timeout cnt", 32'(digit_cnt), 32'd0);
        p0 = pulses;
        send("\r"); idle1(); idle1();
        check("timeout no pulse", 32'(pulses - p0), 32'd0);

        // byte landing on the timeout edge wins
        send("0\r"); idle1();
        check("zero commit err", 32'(err), 32'h0);
        send("34");
        repeat (TMO - 1) cyc(1'b0, 8'h00);
        send("5"); idle1();
        check("edge byte cnt", 32'(digit_cnt), 32'd3);
        check("edge byte err", 32'(err), 32'h0);
        repeat (50) cyc(1'b0, 8'h00);
        send("\r"); idle1();
        check("edge byte Data", 32'(Data), 32'h0345);

        // bad character mid-line
        send("1G"); idle1();
        check("1G err", 32'(err), 32'h1);
        check("1G cnt", 32'(digit_cnt), 32'd0);
        p0 = pulses;
        send("\r\r"); idle1(); idle1();
        check("1G no pulse", 32'(pulses - p0), 32'd0);
        check("1G err sticky", 32'(err), 32'h1);

        // reset is only sampled on an edge
        send("12");
        @(negedge clk);
        rx_valid = 1'b0;
        rtsn = 1'b0;
        #1;
        check("rst no edge cnt", 32'(digit_cnt), 32'd2);
        check("rst no edge Data", 32'(Data), 32'h0345);
        @(negedge clk);
        #1;
        check("rst edge Data", 32'(Data), 32'h0);
        check("rst edge err", 32'(err), 32'h0);
        rtsn = 1'b1;
        send("3\r"); idle1();
        check("post-rst Data", 32'(Data), 32'h0003);

        // back-to-back lines
        p0 = pulses;
        send("AB\r");
        cyc(1'b1, 8'h43); #1;
        check("stream AB", 32'(Data), 32'h00AB);
        send("D\n"); idle1();
        check("stream CD", 32'(Data), 32'h00CD);
        idle1();
        check("stream pulses", 32'(pulses - p0), 32'd2);

        // random traffic
        for (int it = 0; it < 700; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55) begin
                cyc(1'b1, hexchars[$urandom_range(0, 21)]);
            end else if (r < 72) begin
                cyc(1'b1, ($urandom_range(0, 1) == 0) ? 8'h0D : 8'h0A);
            end else if (r < 78) begin
                cyc(1'b1, 8'($urandom_range(0, 255)));
            end else if (r < 96) begin
                repeat ($urandom_range(1, 3)) cyc(1'b0, 8'h00);
            end else begin
                repeat ($urandom_range(TMO - 5, TMO + 5)) cyc(1'b0, 8'h00);
            end
        end
        repeat (5) cyc(1'b0, 8'h00);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_hex_parser.md
Name: uart_hex_parser

Overview:
- Sits between the UART byte receiver and the seven-segment display driver.
- Consumes received ASCII bytes and assembles up to 4 hex digits into a 16-bit word.
- Publishes the word on `Data` when a line terminator arrives; `Data` feeds the display driver directly.
- Flags malformed lines, overlong lines and stalled lines through a sticky error bit.

Parameters:
- NDIGITS, 4: maximum hex digits per line. `Data` width is 4*NDIGITS.
- TIMEOUT_CYCLES, 50_000_000: idle clk cycles allowed inside a partial line before it is discarded. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rtsn  in  1  reset, synchronous, active-low.
- rx_data  in  8  received byte, valid only while rx_valid=1.
- rx_valid  in  1  one-cycle strobe per received byte. Back-to-back strobes are legal.
- Data  out  16  last committed word, right-aligned, zero-extended.
- data_update  out  1  one-cycle pulse; `Data` changed this cycle.
- digit_cnt  out  3  digits held in the current partial line (0..4).
- err  out  1  sticky error. Cleared only by reset or a successful commit.

Behaviour:
- Reset: sampled on posedge clk only. While rtsn=0 at an edge:
  - Data=0, data_update=0, err=0, digit_cnt=0.
  - shadow=0, timer=0, state=IDLE.
  - Reset mid-line discards the partial line.
- Byte classes (evaluated only when rx_valid=1):
  - HEX: 0x30-0x39, 0x41-0x46, 0x61-0x66, giving nibble 0-15.
  - TERM: 0x0D or 0x0A.
  - OTHER: every other byte.
- Register timing: all outputs are registered. The effect of the byte sampled at edge N is visible after edge N. No combinational path from rx_* to any output.
- States:
  - IDLE: shadow=0, digit_cnt=0.
    - HEX -> shadow={shadow[11:0],nib}, digit_cnt=1, go ACCUM.
    - TERM -> ignored (empty line, covers CRLF pairs).
    - OTHER -> ignored, err unchanged.
  - ACCUM (digit_cnt 1..4):
    - HEX with digit_cnt<4 -> shift in nibble, digit_cnt+1.
    - HEX with digit_cnt=4 -> go OVF, err<=1.
    - TERM -> Data<=shadow, data_update<=1, err<=0, shadow<=0, digit_cnt<=0, go IDLE.
    - OTHER -> err<=1, discard shadow, go IDLE.
  - OVF: digit_cnt holds 4 and Data is frozen.
    - HEX and OTHER -> stay in OVF.
    - TERM -> discard, go IDLE, no update.
- Partial lines: fewer than 4 digits are zero-extended because shadow starts at 0. "7" commits 0x0007.
- data_update: high for exactly the one cycle following the committing edge, else 0. Consecutive lines committed on adjacent cycles give adjacent pulses.
- Timeout (ACCUM and OVF only):
  - timer clears on every rx_valid and in IDLE; otherwise it increments.
  - When timer reaches TIMEOUT_CYCLES-1 with no rx_valid: discard, err<=1, go IDLE.
  - rx_valid on that same edge wins: the byte is processed normally and timer clears.
  - timer width: $clog2(TIMEOUT_CYCLES+1), saturating. It never wraps.
- err: no edge both sets and clears it; commit and error events are mutually exclusive by construction.

Decomposition:
- Shared package uart_disp_pkg:
  - ASCII constants CHAR_CR, CHAR_LF, CHAR_0, CHAR_A, CHAR_a.
  - State enum {IDLE, ACCUM, OVF}.
  - Byte-class enum {HEX, TERM, OTHER}.
- One sub-module: ascii_hex_decode, combinational. Input 8-bit byte; outputs is_hex, is_term and 4-bit nib.
- FSM, shadow register and timer live in uart_hex_parser.

Test Plan:
- "1A2F\r": Data=0x1A2F one cycle after the CR edge, single data_update pulse, err=0, digit_cnt back to 0.
- "7\n" then "\r": Data=0x0007, one pulse only; the trailing CR is ignored.
- "12345\r": Data unchanged, err=1, no pulse. Then "00ab\r": Data=0x00AB, err=0.
- TIMEOUT_CYCLES=100: send "12", idle 100 cycles: err=1, digit_cnt=0. Then "\r": no update.
- TIMEOUT_CYCLES=100, rx_valid exactly on the timeout edge: the byte is accepted and timer restarts.
- "1G": err=1, state IDLE. Then "\r\r": no pulse, err stays 1.
- Reset ordering: send "12", drive rtsn=0 without a clk edge: outputs unchanged. Hold rtsn=0 through one edge, release, send "3\r": Data=0x0003.
- Streaming: "AB\r" and "CD\n" on consecutive cycles: Data 0x00AB then 0x00CD, two separate pulses.
